// File: rtl/mips_data_memory.sv
// Word-addressed responder for the MIPS core's fetch and data ports. It clears
// itself after reset, offers a program-load port, and latches the first rejected CPU write.
module mips_data_memory #(
  parameter int          depth_words = 1024,
  parameter logic [31:0] base_addr   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic        data_rd_wr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        mem_ready,
  output logic        wr_err,
  output logic [31:0] wr_err_addr
);

  localparam int AW = $clog2(depth_words);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic           wr_err_q, wr_err_d;
  logic [31:0]    wr_err_addr_q, wr_err_addr_d;

  logic [31:0]    mem_q [depth_words];

  logic           we;
  logic [AW-1:0]  waddr;
  logic [31:0]    wdata;

  logic           running;
  logic           load_hit;
  logic           cpu_wr;
  logic           cpu_ok;
  logic           cpu_rej;

  // Offset is unsigned 32-bit, so addresses below base fail the >= test rather than wrapping.
  function automatic logic in_range(input logic [31:0] a);
    return (a >= base_addr) && (a[1:0] == 2'b00) &&
           (((a - base_addr) >> 2) < 32'(depth_words));
  endfunction

  function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
    return AW'((a - base_addr) >> 2);
  endfunction

  assign running  = (state_q == RUN);
  assign load_hit = running && load_valid && in_range(load_addr);
  assign cpu_wr   = running && !data_rd_wr;
  // The load port owns the single write port whenever it actually writes.
  assign cpu_ok   = cpu_wr && in_range(data_addr) && !load_hit;
  assign cpu_rej  = cpu_wr && !cpu_ok;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_err_d      = wr_err_q;
    wr_err_addr_d = wr_err_addr_q;
    we            = 1'b0;
    waddr         = '0;
    wdata         = '0;
    unique case (state_q)
      CLEAR: begin
        we        = 1'b1;
        waddr     = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(depth_words - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (load_hit) begin
          we    = 1'b1;
          waddr = idx_of(load_addr);
          wdata = load_data;
        end else if (cpu_ok) begin
          we    = 1'b1;
          waddr = idx_of(data_addr);
          wdata = data_out;
        end
        if (cpu_rej && !wr_err_q) begin
          wr_err_d      = 1'b1;
          wr_err_addr_d = data_addr;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      wr_err_q      <= 1'b0;
      wr_err_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_err_q      <= wr_err_d;
      wr_err_addr_q <= wr_err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Storage is only exposed once the clear has finished, so no X ever leaks out.
  assign instr_in    = (running && in_range(instr_addr)) ? mem_q[idx_of(instr_addr)] : 32'h0;
  assign data_in     = (running && in_range(data_addr))  ? mem_q[idx_of(data_addr)]  : 32'h0;

  assign mem_ready   = running;
  assign load_ready  = running;
  assign wr_err      = wr_err_q;
  assign wr_err_addr = wr_err_addr_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed self-checking bench for mips_data_memory with a 16-word array at a
// non-zero base address.
module tb_mips_data_memory;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic [31:0] data_addr;
  logic        data_rd_wr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        mem_ready;
  logic        wr_err;
  logic [31:0] wr_err_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_data_memory #(
    .depth_words(DEPTH),
    .base_addr  (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .data_addr  (data_addr),
    .data_rd_wr (data_rd_wr),
    .data_out   (data_out),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .mem_ready  (mem_ready),
    .wr_err     (wr_err),
    .wr_err_addr(wr_err_addr)
  );

  // Counts falling edges spent with mem_ready low, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!mem_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: mem_ready=%b load_ready=%b, required 0 0", mem_ready, load_ready);
    end
    checks++;
    if (wr_err !== 1'b0 || wr_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_err: wr_err=%b addr=%h, required 0 00000000", wr_err, wr_err_addr);
    end
    checks++;
    if (instr_in !== 32'h0 || data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_read: instr_in=%h data_in=%h, required 0 0", instr_in, data_in);
    end
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL clear_len: cycles=%0d, required %0d", n, DEPTH);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_load_ready: got %b, required 1", load_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      data_addr  = BASE + 32'(4 * i);
      instr_addr = BASE + 32'(4 * i);
      #1;
      checks++;
      if (data_in !== 32'h0 || instr_in !== 32'h0) begin
        errors++;
        $display("FAIL cleared_word[%0d]: data_in=%h instr_in=%h, required 0", i, data_in, instr_in);
      end
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = BASE;
    load_data  = 32'h2408_0005;
    @(negedge clk);
    load_valid = 1'b0;
    instr_addr = BASE;
    #1;
    checks++;
    if (instr_in !== 32'h2408_0005) begin
      errors++;
      $display("FAIL load_fetch: instr_in=%h, required 24080005", instr_in);
    end
    instr_addr = BASE - 32'd4;
    #1;
    checks++;
    if (instr_in !== 32'h0) begin
      errors++;
      $display("FAIL below_base: instr_in=%h, required 00000000", instr_in);
    end
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    data_addr  = BASE + 32'd8;
    data_out   = 32'hCAFE_F00D;
    data_rd_wr = 1'b0;
    #1;
    checks++;
    if (data_in !== 32'h0) begin
      errors++;
      $display("FAIL read_old: data_in=%h, required 00000000", data_in);
    end
    @(negedge clk);
    @(negedge clk);
    data_rd_wr = 1'b1;
    #1;
    checks++;
    if (data_in !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL cpu_write: data_in=%h, required cafef00d", data_in);
    end
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL cpu_write_err: wr_err=%b, required 0", wr_err);
    end
  endtask

  task automatic test_bad_writes();
    @(negedge clk);
    data_addr  = BASE + 32'd6;
    data_out   = 32'hDEAD_BEEF;
    data_rd_wr = 1'b0;
    @(negedge clk);
    data_addr  = BASE + 32'(4 * DEPTH);
    data_out   = 32'hBAD0_BAD0;
    @(negedge clk);
    data_rd_wr = 1'b1;
    #1;
    checks++;
    if (wr_err !== 1'b1 || wr_err_addr !== BASE + 32'd6) begin
      errors++;
      $display("FAIL bad_write_err: wr_err=%b addr=%h, required 1 %h", wr_err, wr_err_addr, BASE + 32'd6);
    end
    data_addr = BASE + 32'd4;
    #1;
    checks++;
    if (data_in !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_target: data_in=%h, required 00000000", data_in);
    end
    data_addr = BASE;
    #1;
    checks++;
    if (data_in !== 32'h2408_0005) begin
      errors++;
      $display("FAIL oor_target: data_in=%h, required 24080005", data_in);
    end
  endtask

  task automatic test_conflict();
    int n;
    pulse_reset();
    wait_ready(n);
    checks++;
    if (n !== DEPTH || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_prep: cycles=%0d wr_err=%b, required %0d 0", n, wr_err, DEPTH);
    end
    load_valid = 1'b1;
    load_addr  = BASE + 32'd4;
    load_data  = 32'h1111_1111;
    data_addr  = BASE + 32'd12;
    data_out   = 32'h2222_2222;
    data_rd_wr = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    data_rd_wr = 1'b1;
    data_addr  = BASE + 32'd4;
    #1;
    checks++;
    if (data_in !== 32'h1111_1111) begin
      errors++;
      $display("FAIL conflict_load: data_in=%h, required 11111111", data_in);
    end
    data_addr = BASE + 32'd12;
    #1;
    checks++;
    if (data_in !== 32'h0) begin
      errors++;
      $display("FAIL conflict_cpu: data_in=%h, required 00000000", data_in);
    end
    checks++;
    if (wr_err !== 1'b1 || wr_err_addr !== BASE + 32'd12) begin
      errors++;
      $display("FAIL conflict_err: wr_err=%b addr=%h, required 1 %h", wr_err, wr_err_addr, BASE + 32'd12);
    end
    // A later bad write must not overwrite the captured address.
    @(negedge clk);
    data_addr  = BASE + 32'd2;
    data_rd_wr = 1'b0;
    @(negedge clk);
    data_rd_wr = 1'b1;
    #1;
    checks++;
    if (wr_err_addr !== BASE + 32'd12) begin
      errors++;
      $display("FAIL err_sticky: addr=%h, required %h", wr_err_addr, BASE + 32'd12);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = BASE + 32'd20;
    load_data  = 32'h5555_AAAA;
    @(negedge clk);
    load_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: mem_ready=%b, required 0", mem_ready);
    end
    // Writes during the clear are ignored and raise no error.
    data_addr  = BASE + 32'd3;
    data_out   = 32'h7777_7777;
    data_rd_wr = 1'b0;
    wait_ready(n);
    data_rd_wr = 1'b1;
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL mid_clear_len: cycles=%0d, required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      data_addr = BASE + 32'(4 * i);
      #1;
      checks++;
      if (data_in !== 32'h0) begin
        errors++;
        $display("FAIL mid_cleared[%0d]: data_in=%h, required 00000000", i, data_in);
      end
    end
    checks++;
    if (wr_err !== 1'b0 || wr_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL mid_err: wr_err=%b addr=%h, required 0 00000000", wr_err, wr_err_addr);
    end
  endtask

  initial begin
    reset      = 1'b0;
    instr_addr = BASE;
    data_addr  = BASE;
    data_rd_wr = 1'b1;
    data_out   = '0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    test_reset();
    test_load();
    test_cpu_write();
    test_bad_writes();
    test_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_data_memory.md
Name: mips_data_memory

Overview:
- Word-addressed, single-write-port memory that acts as the responder for the MIPS core's instruction-fetch and data-memory interfaces.
- Returns instructions on instr_in for instr_addr.
- Services load/store traffic on data_addr, data_rd_wr, data_out, and returns read data on data_in.
- Adds a post-reset clear sequencer, a testbench/boot program-load port with valid/ready handshake, and sticky error capture for bad CPU writes.

Parameters:
- depth_words, 1024: number of 32-bit words; must be a power of two, ≥4.
- base_addr, 32'h0000_0000: byte address mapped to word 0; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- instr_addr  in  32  fetch byte address from core.
- instr_in  out  32  instruction word to core.
- data_addr  in  32  load/store byte address from core.
- data_rd_wr  in  1  1 = read, 0 = write.
- data_out  in  32  store data from core.
- data_in  out  32  load data to core.
- load_valid  in  1  program-load word offered.
- load_addr  in  32  program-load byte address.
- load_data  in  32  program-load word.
- load_ready  out  1  load word accepted this cycle when load_valid & load_ready.
- mem_ready  out  1  clear sequence finished; memory usable.
- wr_err  out  1  sticky: a CPU write was rejected.
- wr_err_addr  out  32  data_addr of the first rejected CPU write.

Behaviour:
- Address decode, applied to any address A:
  - in_range = A ≥ base_addr, A[1:0] == 0, and ((A − base_addr) >> 2) < depth_words.
  - idx = (A − base_addr) >> 2, truncated to log2(depth_words) bits.
  - Subtraction is 32-bit unsigned; no wrap-around into the array.
- Reads are asynchronous, zero latency:
  - instr_in = mem[idx(instr_addr)] if in_range and mem_ready, else 32'h0 (sll $0 = NOP).
  - data_in uses the same rule on data_addr, independent of data_rd_wr.
  - A read of a word being written this cycle returns the old value; the new value is visible next cycle.
- FSM states: CLEAR, RUN.
- reset = 1:
  - state ← CLEAR, clr_cnt ← 0, wr_err ← 0, wr_err_addr ← 0.
  - mem_ready = 0 and load_ready = 0 while in CLEAR; both outputs are registered/derived from state.
- CLEAR:
  - Each cycle writes mem[clr_cnt] ← 0, then clr_cnt ← clr_cnt + 1.
  - After the write of index depth_words−1, state ← RUN.
  - Clear therefore takes exactly depth_words cycles after reset deasserts.
  - CPU writes and load_valid are ignored in CLEAR; no error is flagged.
- RUN:
  - mem_ready = 1 and load_ready = 1.
  - Load write: on load_valid with in_range(load_addr), mem[idx] ← load_data at posedge. An out-of-range load is accepted but discarded.
  - CPU write: when data_rd_wr = 0, mem[idx(data_addr)] ← data_out at posedge, if in_range.
  - A CPU write with !in_range is dropped. If wr_err was 0: wr_err ← 1 and wr_err_addr ← data_addr.
  - Single write port, so load and CPU write in the same cycle resolve as load wins. The CPU write is dropped and flagged as above; this applies whether or not the indices match.
  - Repeating an identical CPU write on consecutive cycles is legal and idempotent.
- wr_err and wr_err_addr hold until reset; later errors do not overwrite them.
- Reset mid-operation:
  - Reset asserted during CLEAR or RUN restarts CLEAR from index 0 on the next cycle.
  - Any write presented in the reset cycle is discarded.
  - Memory contents are undefined until CLEAR completes.
- No X propagation: instr_in and data_in are never driven from unwritten storage while mem_ready = 0.

Test Plan:
- Reset for 1 cycle with depth_words=16 → mem_ready 0 for exactly 16 cycles, then 1. Reading any in-range address then returns 32'h0.
- Load 0x2408_0005 at base+0 via load port, then drive instr_addr=base+0 → instr_in = 0x2408_0005 in the same cycle.
- CPU write data_addr=base+8, data_out=0xCAFEF00D, data_rd_wr=0 for 2 cycles, then read with data_rd_wr=1 → data_in = 0xCAFEF00D and wr_err = 0.
- Misaligned CPU write at base+6, then out-of-range write at base+4*depth_words → wr_err = 1, wr_err_addr = base+6; target words unchanged.
- Same cycle: load base+4 = 0x1111_1111 and CPU write base+12 = 0x2222_2222 → mem[1] = 0x1111_1111, mem[3] unchanged, wr_err = 1, wr_err_addr = base+12.
- Assert reset mid-RUN after loading data → mem_ready drops the next cycle; after depth_words cycles all words read 0 and wr_err = 0.
